// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq
//   Column-serial AES-128 InvMixColumns stage. Accepts a 128-bit state and
//   its round number, transforms one 32-bit column per clock, and presents
//   the result on a valid/ready output. The last round is passed through
//   unchanged because InvMixColumns is skipped there.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   data_in    128-bit state, byte 0 = [127:120], column c = [127-32c -: 32]
//   count_out  round number of the block on data_in
//   in_valid   data_in/count_out valid
//   in_ready   block can accept input (IDLE only)
//   data_out   transformed (or bypassed) state
//   out_valid  data_out valid
//   out_ready  downstream accepts data_out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for input; in_ready high
// COL   | transforming column col of the captured state, one per cycle
// DONE  | result held on data_out with out_valid high until out_ready

module inv_mix_columns_seq #(
  parameter logic [3:0] LAST_ROUND = 4'd9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic [3:0]   count_out,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] data_out,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   col;
  logic [127:0] work;
  logic [3:0]   round;
  logic [31:0]  col_word;
  logic [31:0]  col_result;

  // GF(2^8) multiply by x, reduction polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse MixColumns coefficients built from the x2/x4/x8 chain:
  //   09 = x8^x, 0b = x8^x2^x, 0d = x8^x4^x, 0e = x8^x4^x2
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Columns are always read from the captured state, never from data_out
  always_comb begin
    col_word = work[127:96];
    case (col)
      2'd0: col_word = work[127:96];
      2'd1: col_word = work[95:64];
      2'd2: col_word = work[63:32];
      2'd3: col_word = work[31:0];
      default: col_word = work[127:96];
    endcase
    col_result = inv_mix_col(col_word);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (count_out == LAST_ROUND) state_next = DONE;
          else                         state_next = COL;
        end
      end
      // The round check is defensive: a last-round block never enters COL
      COL: begin
        if (col == 2'd3 || round == LAST_ROUND) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      round    <= '0;
      col      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= data_in;
            round <= count_out;
            col   <= '0;
            if (count_out == LAST_ROUND) data_out <= data_in;
          end
        end
        COL: begin
          case (col)
            2'd0: data_out[127:96] <= col_result;
            2'd1: data_out[95:64]  <= col_result;
            2'd2: data_out[63:32]  <= col_result;
            2'd3: data_out[31:0]   <= col_result;
            default: data_out[127:96] <= col_result;
          endcase
          // Wraps from 3 back to 0 as the last column is written
          col <= col + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq
//   Directed bench for inv_mix_columns_seq: reset state, transform and
//   bypass paths, latency, backpressure, reset mid-transform, back-to-back
//   blocks and the identity column.

module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic [127:0] data_in;
  logic [3:0]   count_out;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  localparam logic [127:0] VEC_IN   = 128'h8e4da1bc_01010101_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] VEC_OUT  = 128'hdb135345_01010101_d4d4d4d5_2d26314c;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C6_ALL   = {4{32'hc6c6c6c6}};
  localparam logic [127:0] D5_IN    = {4{32'hd5d5d7d6}};
  localparam logic [127:0] D5_OUT   = {4{32'hd4d4d4d5}};

  inv_mix_columns_seq #(.LAST_ROUND(4'd9)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .count_out (count_out),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a block and returns just after its acceptance edge
  task automatic send(input logic [127:0] d, input logic [3:0] c, input bit keep_valid);
    int guard;
    data_in   = d;
    count_out = c;
    in_valid  = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("accept_timeout", 128'(in_ready), 128'(1));
    tick();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Edges counted from the acceptance edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) check("valid_timeout", 128'(out_valid), 128'(1));
  endtask

  initial begin
    int lat;
    int t1, t2;
    logic [127:0] held;

    rst       = 1'b1;
    data_in   = '0;
    count_out = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data_out",  data_out,        128'h0);
    rst = 1'b0;
    tick();

    // Normal-round transform
    send(VEC_IN, 4'd3, 1'b0);
    wait_valid(lat);
    check("xform_latency", 128'(lat), 128'(4));
    check("xform_data",    data_out,  VEC_OUT);
    tick();
    check("xform_release", 128'(in_ready), 128'(1));

    // Bypass in the last round
    send(BYP_IN, 4'd9, 1'b0);
    wait_valid(lat);
    check("bypass_latency", 128'(lat), 128'(0));
    check("bypass_data",    data_out,  BYP_IN);
    tick();

    // Rounds above LAST_ROUND still transform
    send(VEC_IN, 4'd12, 1'b0);
    wait_valid(lat);
    check("round12_latency", 128'(lat), 128'(4));
    check("round12_data",    data_out,  VEC_OUT);
    tick();

    // Identity column
    send(C6_ALL, 4'd0, 1'b0);
    wait_valid(lat);
    check("identity_data", data_out, C6_ALL);
    tick();

    // Backpressure with an ignored input pulse
    out_ready = 1'b0;
    send(D5_IN, 4'd1, 1'b0);
    wait_valid(lat);
    held = data_out;
    check("bp_data", held, D5_OUT);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        data_in   = BYP_IN;
        count_out = 4'd9;
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("bp_stable",    data_out,            held);
      check("bp_in_ready",  128'(in_ready),      128'(0));
      check("bp_out_valid", 128'(out_valid),     128'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 128'(in_ready),  128'(1));
    check("bp_release_valid", 128'(out_valid), 128'(0));
    repeat (3) tick();
    check("bp_pulse_ignored", 128'(out_valid), 128'(0));
    check("bp_data_kept",     data_out,        held);

    // Reset during the second column cycle
    send(VEC_IN, 4'd2, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready",  128'(in_ready),  128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_data_out",  data_out,        128'h0);
    send(VEC_IN, 4'd5, 1'b0);
    wait_valid(lat);
    check("postrst_latency", 128'(lat), 128'(4));
    check("postrst_data",    data_out,  VEC_OUT);
    tick();

    // Back-to-back with in_valid held high; second block only taken in IDLE
    send(VEC_IN, 4'd4, 1'b1);
    data_in   = D5_IN;
    count_out = 4'd6;
    wait_valid(lat);
    t1 = cyc;
    check("b2b_first", data_out, VEC_OUT);
    tick();
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) check("b2b_timeout", 128'(out_valid), 128'(1));
    t2 = cyc;
    in_valid = 1'b0;
    check("b2b_second",  data_out,     D5_OUT);
    check("b2b_spacing", 128'(t2 - t1), 128'(6));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
